// File: rtl/pipe_run_ctrl_if.sv
// pipe_run_ctrl_if: bus bundle between the run sequencer and its environment.
//   cmd_*      : image load stream (valid/ready), plus dump window descriptor
//                dump_base/dump_len sampled with the final load word.
//   mem_*      : controller-side port into the core's unified memory;
//                mem_rdata returns one cycle after mem_re.
//   out_*      : dump stream back to the sink (valid/ready, last marker).
// Modports: slave = the sequencer, master = the environment driving it.
interface pipe_run_ctrl_if #(
  parameter int AW = 10
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [31:0]   cmd_data;
  logic          cmd_last;
  logic [AW-1:0] dump_base;
  logic [7:0]    dump_len;

  logic          mem_we;
  logic          mem_re;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_data;
  logic          out_last;

  modport slave (
    input  cmd_valid, cmd_addr, cmd_data, cmd_last, dump_base, dump_len,
    input  mem_rdata, out_ready,
    output cmd_ready, mem_we, mem_re, mem_addr, mem_wdata,
    output out_valid, out_data, out_last
  );

  modport master (
    output cmd_valid, cmd_addr, cmd_data, cmd_last, dump_base, dump_len,
    output mem_rdata, out_ready,
    input  cmd_ready, mem_we, mem_re, mem_addr, mem_wdata,
    input  out_valid, out_data, out_last
  );
endinterface

// File: rtl/pipe_run_ctrl.sv
// pipe_run_ctrl: run sequencer for the pipelined MIPS32 core.
// Loads a program/data image into the core memory, releases the core, counts
// run cycles until HALTED (or TIMEOUT), lets the pipeline drain, then streams
// a window of memory back out.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   bus (slave)   : load stream, memory port, dump stream (see pipe_run_ctrl_if)
//   core_hold     : core frozen, controller owns memory
//   core_clr      : one-cycle pulse clearing PC/HALTED/TAKEN_BRANCH
//   core_halted   : core HALTED flag
//   busy          : sequencer active (not IDLE/DONE)
//   done, timeout : sticky completion / abort flags
//   cycle_count   : saturating count of run cycles
module pipe_run_ctrl #(
  parameter int AW      = 10,
  parameter int TIMEOUT = 50000,
  parameter int DRAIN   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  pipe_run_ctrl_if.slave bus,
  output logic        core_hold,
  output logic        core_clr,
  input  logic        core_halted,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [31:0] cycle_count
);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_CLEAR, S_RUN, S_DRAIN,
    S_DUMP_RD, S_DUMP_WAIT, S_DUMP_OUT, S_DONE
  } state_t;

  localparam logic [31:0] TIMEOUT_W  = 32'(TIMEOUT);
  localparam logic [15:0] DRAIN_LAST = 16'((DRAIN > 0) ? DRAIN - 1 : 0);

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  state_t        r_state;
  state_t        w_nxt;
  logic          r_cmd_ready;
  logic          r_core_hold;
  logic          r_core_clr;
  logic          r_out_valid;
  logic          r_out_last;
  logic [31:0]   r_out_data;
  logic          r_busy;
  logic          r_done;
  logic          r_timeout;
  logic [31:0]   r_cycles;
  logic [7:0]    r_idx;
  logic [15:0]   r_dcnt;
  logic [AW-1:0] r_base;
  logic [7:0]    r_len;

  logic          w_hs;
  logic          w_hs_last;
  logic [31:0]   w_cyc_inc;
  logic          w_to;
  logic          w_drain_end;
  logic          w_out_hs;
  logic          w_last_word;
  logic          w_re;

  assign w_hs        = bus.cmd_valid & r_cmd_ready;
  assign w_hs_last   = w_hs & bus.cmd_last;
  assign w_cyc_inc   = sat_inc(r_cycles);
  // A halt seen in the same cycle as the limit wins, so timeout is masked by it.
  assign w_to        = (r_state == S_RUN) & ~core_halted & (w_cyc_inc >= TIMEOUT_W);
  assign w_drain_end = (r_state == S_DRAIN) & (r_dcnt >= DRAIN_LAST);
  assign w_out_hs    = (r_state == S_DUMP_OUT) & r_out_valid & bus.out_ready;
  assign w_last_word = (r_idx + 8'd1) == r_len;
  assign w_re        = (r_state == S_DUMP_RD);

  // Load writes pass straight through from the handshake; dump reads use the
  // latched window base plus the running word index (wraps mod 2^AW).
  assign bus.mem_we    = w_hs;
  assign bus.mem_re    = w_re;
  assign bus.mem_addr  = w_hs ? bus.cmd_addr : (w_re ? r_base + AW'(r_idx) : '0);
  assign bus.mem_wdata = w_hs ? bus.cmd_data : 32'd0;

  assign bus.cmd_ready = r_cmd_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_last  = r_out_last;
  assign core_hold     = r_core_hold;
  assign core_clr      = r_core_clr;
  assign busy          = r_busy;
  assign done          = r_done;
  assign timeout       = r_timeout;
  assign cycle_count   = r_cycles;

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (w_hs) w_nxt = bus.cmd_last ? S_CLEAR : S_LOAD;
      S_LOAD:         if (w_hs_last) w_nxt = S_CLEAR;
      S_CLEAR:        w_nxt = S_RUN;
      S_RUN:          if (core_halted || w_to) w_nxt = S_DRAIN;
      S_DRAIN:        if (w_drain_end) w_nxt = (r_len == 8'd0) ? S_DONE : S_DUMP_RD;
      S_DUMP_RD:      w_nxt = S_DUMP_WAIT;
      S_DUMP_WAIT:    w_nxt = S_DUMP_OUT;
      S_DUMP_OUT:     if (w_out_hs) w_nxt = w_last_word ? S_DONE : S_DUMP_RD;
      default:        w_nxt = S_IDLE;
    endcase
  end

  // Sequencer state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cmd_ready <= 1'b0;
      r_core_hold <= 1'b1;
      r_core_clr  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= 32'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_timeout   <= 1'b0;
      r_cycles    <= 32'd0;
      r_idx       <= 8'd0;
      r_dcnt      <= 16'd0;
    end else begin
      r_state     <= w_nxt;
      r_cmd_ready <= (w_nxt == S_IDLE) || (w_nxt == S_LOAD) || (w_nxt == S_DONE);
      r_busy      <= !((w_nxt == S_IDLE) || (w_nxt == S_DONE));
      r_core_clr  <= (w_nxt == S_CLEAR);

      // Core runs through RUN; after a real halt it keeps running for the
      // drain window so MEM/WB retire, but a timeout freezes it at once.
      if (w_nxt == S_RUN)
        r_core_hold <= 1'b0;
      else if (w_nxt == S_DRAIN && r_state == S_RUN)
        r_core_hold <= w_to;
      else if (w_nxt != S_DRAIN)
        r_core_hold <= 1'b1;

      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_hs) begin
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            r_cycles  <= 32'd0;
          end
        end
        S_CLEAR: r_idx <= 8'd0;
        S_RUN: begin
          r_cycles <= w_cyc_inc;
          r_dcnt   <= 16'd0;
          if (w_to) r_timeout <= 1'b1;
        end
        S_DRAIN: begin
          r_dcnt <= r_dcnt + 16'd1;
          if (w_drain_end && r_len == 8'd0) r_done <= 1'b1;
        end
        S_DUMP_WAIT: begin
          r_out_data  <= bus.mem_rdata;
          r_out_valid <= 1'b1;
          r_out_last  <= w_last_word;
        end
        S_DUMP_OUT: begin
          if (w_out_hs) begin
            r_out_valid <= 1'b0;
            r_idx       <= r_idx + 8'd1;
            if (w_last_word) r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Dump window descriptor, captured with the final load word
  always_ff @(posedge clk) begin
    if (w_hs_last) begin
      r_base <= bus.dump_base;
      r_len  <= bus.dump_len;
    end
  end

endmodule

// File: tb/tb_pipe_run_ctrl.sv
// Testbench for pipe_run_ctrl: behavioural memory plus a stand-in core that
// raises HALTED after a chosen number of released cycles (optionally sorting
// words 100..119, as the bubble-sort program would). Expected dump contents,
// cycle counts and flags come from a reference image kept by the bench.
module tb_pipe_run_ctrl;
  localparam int AW = 10;
  localparam int TO = 200;
  localparam int DR = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_run_ctrl_if #(.AW(AW)) bus ();
  logic        core_hold, core_clr, core_halted, busy, done, timeout;
  logic [31:0] cycle_count;

  pipe_run_ctrl #(.AW(AW), .TIMEOUT(TO), .DRAIN(DR)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .core_hold(core_hold), .core_clr(core_clr), .core_halted(core_halted),
    .busy(busy), .done(done), .timeout(timeout), .cycle_count(cycle_count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Memory and stand-in core
  logic [31:0] mem [0:1023];
  int halt_after = 0;
  bit sort_en = 0;
  int k = 0;

  function automatic logic [31:0] kth(input int j);
    logic [31:0] w [20];
    logic [31:0] t;
    for (int i = 0; i < 20; i++) w[i] = mem[100+i];
    for (int p = 0; p < 19; p++)
      for (int i = 0; i < 19 - p; i++)
        if (w[i] > w[i+1]) begin t = w[i]; w[i] = w[i+1]; w[i+1] = t; end
    return w[j];
  endfunction

  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr];
    if (core_clr) begin
      k <= 0;
      core_halted <= 1'b0;
    end else if (!core_hold) begin
      k <= k + 1;
      if (k + 1 == halt_after) begin
        core_halted <= 1'b1;
        if (sort_en) for (int j = 0; j < 20; j++) mem[100+j] <= kth(j);
      end
    end
  end

  // Reference image and expected dump
  logic [31:0]   rm [0:1023];
  logic [31:0]   exp_d [$];
  logic [AW-1:0] exp_a [$];
  logic [AW-1:0] img_a [$];
  logic [31:0]   img_d [$];

  int or_mode = 0;
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (or_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = ~bus.out_ready;
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  // Monitor, sampled on the falling edge
  int clr_cnt = 0, ov_cnt = 0, hs_cnt = 0, extra_cnt = 0;
  initial begin
    bit prev_stall;
    logic [31:0] prev_d;
    logic prev_l;
    prev_stall = 0; prev_d = 0; prev_l = 0;
    forever begin
      @(negedge clk);
      if (core_clr) clr_cnt++;
      if (bus.out_valid) ov_cnt++;
      if (rst_n && !core_hold) begin
        chk_eq("run_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        chk_eq("run_mem_we", 32'(bus.mem_we), 32'd0);
      end
      if (rst_n && prev_stall) begin
        chk_eq("stall_data", bus.out_data, prev_d);
        chk_eq("stall_last", 32'(bus.out_last), 32'(prev_l));
        chk_eq("stall_valid", 32'(bus.out_valid), 32'd1);
      end
      prev_stall = rst_n && bus.out_valid && !bus.out_ready;
      prev_d = bus.out_data;
      prev_l = bus.out_last;
      if (rst_n && bus.mem_re) begin
        if (exp_a.size() == 0) extra_cnt++;
        else chk_eq("rd_addr", 32'(bus.mem_addr), 32'(exp_a.pop_front()));
      end
      if (rst_n && bus.out_valid && bus.out_ready) begin
        hs_cnt++;
        if (exp_d.size() == 0) extra_cnt++;
        else begin
          chk_eq("out_data", bus.out_data, exp_d.pop_front());
          chk_eq("out_last", 32'(bus.out_last), 32'(exp_d.size() == 0));
        end
      end
    end
  end

  task automatic wait_rdy(input string tag);
    int i = 0;
    do begin @(negedge clk); i++; end while (!bus.cmd_ready && i < 2000);
    chk_eq({tag, ".cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
  endtask

  task automatic send(input logic [AW-1:0] a, input logic [31:0] d, input bit last,
                      input logic [AW-1:0] base, input logic [7:0] len);
    repeat ($urandom_range(0, 2)) @(posedge clk);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1; bus.cmd_addr = a; bus.cmd_data = d;
    bus.cmd_last = last; bus.dump_base = base; bus.dump_len = len;
    wait_rdy("send");
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0; bus.cmd_last = 1'b0;
    rm[a] = d;
  endtask

  task automatic wait_done(input string tag, output logic hold_before);
    int i = 0;
    logic ph;
    ph = core_hold;
    do begin ph = core_hold; @(negedge clk); i++; end while (!(done && !busy) && i < 5000);
    chk_eq({tag, ".done"}, 32'(done), 32'd1);
    hold_before = ph;
  endtask

  task automatic build_expect(input logic [AW-1:0] base, input logic [7:0] len);
    for (int i = 0; i < int'(len); i++) begin
      logic [AW-1:0] a;
      a = base + AW'(i);
      exp_a.push_back(a);
      exp_d.push_back(rm[a]);
    end
  endtask

  task automatic run_case(input string tag, input int h, input bit srt,
                          input logic [AW-1:0] base, input logic [7:0] len,
                          output logic hold_before);
    int c0, hs0, ov0, exp_cnt;
    bit exp_to;
    halt_after = h; sort_en = srt;
    c0 = clr_cnt; hs0 = hs_cnt; ov0 = ov_cnt; extra_cnt = 0;
    for (int i = 0; i < img_a.size(); i++)
      send(img_a[i], img_d[i], i == img_a.size() - 1, base, len);
    // Halt is sampled one run cycle after the core raises it.
    exp_to  = !(h > 0 && h + 1 <= TO);
    exp_cnt = exp_to ? TO : h + 1;
    if (!exp_to && srt) begin
      logic [31:0] q [$];
      for (int i = 0; i < 20; i++) q.push_back(rm[100+i]);
      q.sort();
      for (int i = 0; i < 20; i++) rm[100+i] = q[i];
    end
    build_expect(base, len);
    wait_done(tag, hold_before);
    chk_eq({tag, ".cycles"}, cycle_count, 32'(exp_cnt));
    chk_eq({tag, ".timeout"}, 32'(timeout), 32'(exp_to));
    chk_eq({tag, ".hold"}, 32'(core_hold), 32'd1);
    chk_eq({tag, ".clr_pulses"}, 32'(clr_cnt - c0), 32'd1);
    chk_eq({tag, ".handshakes"}, 32'(hs_cnt - hs0), 32'(len));
    chk_eq({tag, ".missing"}, 32'(exp_d.size()), 32'd0);
    chk_eq({tag, ".extra"}, 32'(extra_cnt), 32'd0);
    if (len == 8'd0) chk_eq({tag, ".no_out"}, 32'(ov_cnt - ov0), 32'd0);
  endtask

  task automatic chk_reset(input string tag);
    chk_eq({tag, ".cmd_ready"}, 32'(bus.cmd_ready), 32'd0);
    chk_eq({tag, ".mem"}, {29'd0, bus.mem_we, bus.mem_re, |bus.mem_addr}, 32'd0);
    chk_eq({tag, ".wdata"}, bus.mem_wdata, 32'd0);
    chk_eq({tag, ".hold_clr"}, {30'd0, core_hold, core_clr}, 32'd2);
    chk_eq({tag, ".out"}, {30'd0, bus.out_valid, bus.out_last}, 32'd0);
    chk_eq({tag, ".out_data"}, bus.out_data, 32'd0);
    chk_eq({tag, ".flags"}, {29'd0, busy, done, timeout}, 32'd0);
    chk_eq({tag, ".cycles"}, cycle_count, 32'd0);
  endtask

  initial begin
    logic hb;
    int h, i;
    bus.cmd_valid = 0; bus.cmd_addr = '0; bus.cmd_data = '0; bus.cmd_last = 0;
    bus.dump_base = '0; bus.dump_len = '0;
    repeat (3) @(posedge clk);
    #1 chk_reset("reset");
    rst_n = 1'b1;

    // Sort program: 51 program words then data 20..1, core sorts the window.
    img_a.delete(); img_d.delete();
    for (int a = 0; a <= 50; a++) begin img_a.push_back(AW'(a)); img_d.push_back($urandom); end
    for (int a = 0; a < 20; a++) begin img_a.push_back(AW'(100 + a)); img_d.push_back(32'(20 - a)); end
    run_case("sort", $urandom_range(30, 150), 1, 10'd100, 8'd20, hb);
    chk_eq("sort.word0", rm[100], 32'd1);

    // Single HLT, empty dump: done appears the edge the drain window ends.
    img_a.delete(); img_d.delete();
    img_a.push_back(10'd0); img_d.push_back(32'hFC00_0000);
    run_case("hlt", 4, 0, 10'd0, 8'd0, hb);
    chk_eq("hlt.released_before_done", 32'(hb), 32'd0);

    // Infinite loop: runs into the timeout, still dumps.
    img_a.delete(); img_d.delete();
    img_a.push_back(10'd0); img_d.push_back(32'h1000_FFFF);
    run_case("loop", 0, 0, 10'd0, 8'd5, hb);

    // Wrapping dump window with a toggling sink.
    img_a.delete(); img_d.delete();
    for (int a = 0; a < 8; a++) begin
      img_a.push_back(10'd1020 + AW'(a)); img_d.push_back($urandom);
    end
    or_mode = 1;
    run_case("wrap", $urandom_range(5, 50), 0, 10'd1020, 8'd8, hb);
    or_mode = 0;

    // Halt and limit land on the same cycle: halt wins.
    img_a.delete(); img_d.delete();
    img_a.push_back(10'd0); img_d.push_back(32'hFC00_0000);
    run_case("tie", TO - 1, 0, 10'd0, 8'd1, hb);

    // Reset while word 5 of a timed-out run's dump is stalled.
    halt_after = 0; sort_en = 0; extra_cnt = 0;
    h = hs_cnt;
    send(10'd40, $urandom, 1, 10'd40, 8'd10);
    build_expect(10'd40, 8'd10);
    i = 0;
    while (hs_cnt - h < 5 && i < 3000) begin @(negedge clk); i++; end
    chk_eq("rst.words_before", 32'(hs_cnt - h), 32'd5);
    or_mode = 2;
    i = 0;
    do begin @(negedge clk); i++; end while (!bus.out_valid && i < 50);
    chk_eq("rst.stalled_valid", 32'(bus.out_valid), 32'd1);
    chk_eq("rst.pre_timeout", 32'(timeout), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_reset("midreset");
    exp_a.delete(); exp_d.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    or_mode = 0;
    img_a.delete(); img_d.delete();
    img_a.push_back(10'd0); img_d.push_back(32'hFC00_0000);
    run_case("post_rst", 3, 0, 10'd0, 8'd0, hb);

    // Load stream held valid through the run: stalled, then taken in DONE.
    halt_after = 6; sort_en = 0;
    send(10'd0, 32'hFC00_0000, 1, 10'd0, 8'd0);
    bus.cmd_valid = 1'b1; bus.cmd_addr = 10'd7; bus.cmd_data = 32'h1234_5678;
    bus.cmd_last = 1'b1; bus.dump_base = 10'd0; bus.dump_len = 8'd0;
    wait_rdy("held");
    chk_eq("held.done_at_accept", 32'(done), 32'd1);
    chk_eq("held.cycles_first", cycle_count, 32'd7);
    halt_after = 2;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0; bus.cmd_last = 1'b0;
    rm[7] = 32'h1234_5678;
    wait_done("held", hb);
    chk_eq("held.cycles_second", cycle_count, 32'd3);
    chk_eq("held.mem_written", mem[7], rm[7]);
    chk_eq("held.timeout", 32'(timeout), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
